// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO for a UART: first-word-fall-through buffer with occupancy
// flags and a sticky overrun indicator for characters dropped while full.
module uart_rx_fifo #(
  parameter int unsigned DATA_BITS   = 8,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned AFULL_LEVEL = DEPTH - 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       i_data_valid,
  input  logic [DATA_BITS-1:0]       i_data,
  output logic [DATA_BITS-1:0]       o_data,
  output logic                       o_data_valid,
  input  logic                       i_data_ready,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_almost_full,
  output logic                       o_overrun,
  input  logic                       i_clear_overrun
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] AFULL = PW'(AFULL_LEVEL);

  logic [DATA_BITS-1:0] mem [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic [PW-1:0]        count;
  logic                 empty;
  logic                 full;
  logic                 pop;
  logic                 push;
  logic                 overrun_set;

  // Pointers carry an extra wrap bit so full and empty are distinguishable.
  always_comb begin
    empty       = (wr_ptr == rd_ptr);
    full        = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    count       = wr_ptr - rd_ptr;
    pop         = !empty && i_data_ready;
    push        = i_data_valid && (!full || pop);
    overrun_set = i_data_valid && full && !pop;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      o_overrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      if (overrun_set)          o_overrun <= 1'b1;
      else if (i_clear_overrun) o_overrun <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= i_data;
  end

  always_comb begin
    o_data        = mem[rd_ptr[AW-1:0]];
    o_data_valid  = !empty;
    o_count       = count;
    o_full        = full;
    o_almost_full = (count >= AFULL);
  end

endmodule
